// File: rtl/bin_to_ascii_dec.sv
// rtl/bin_to_ascii_dec.sv - iterative binary-to-ASCII decimal formatter with fixed-width streamed field
module bin_to_ascii_dec #(
    parameter int WIDTH   = 8,
    parameter int DIGITS  = 3,
    parameter int JUSTIFY = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] value,
    input  logic             signed_mode,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_char,
    output logic             out_last
);

    // Decimal digits needed to print the largest unsigned WIDTH-bit value.
    function automatic int min_digits(input int w);
        longint m;
        int     n;
        m = (longint'(1) << w) - 1;
        n = 0;
        while (m > 0) begin
            m = m / 10;
            n = n + 1;
        end
        return n;
    endfunction

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH);
    localparam int KW = $clog2(DIGITS + 2);

    if (DIGITS < min_digits(WIDTH)) begin : g_digits_too_small
        $error("bin_to_ascii_dec: DIGITS too small for WIDTH");
    end

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PREP = 3'd1;
    localparam logic [2:0] S_CONV = 3'd2;
    localparam logic [2:0] S_SCAN = 3'd3;
    localparam logic [2:0] S_EMIT = 3'd4;

    logic [2:0]       state;
    logic [WIDTH-1:0] val_q;
    logic [WIDTH-1:0] mag_q;
    logic             sgn_q;
    logic             neg_q;
    logic             nz_q;
    logic [BW-1:0]    bcd_q;
    logic [CW-1:0]    cnt_q;
    logic [KW-1:0]    ndig_q;
    logic [KW-1:0]    k_q;

    logic [BW-1:0]    bcd_adj;
    logic [KW-1:0]    ndig_c;
    logic [KW-1:0]    sign_len;
    logic [KW-1:0]    field_len;
    logic [KW-1:0]    str_len;
    logic [KW-1:0]    pad_len;
    logic [KW-1:0]    pos;
    logic [KW-1:0]    didx;
    logic             is_pad;
    logic [3:0]       digit;
    logic [7:0]       char_c;

    assign busy = (state != S_IDLE);

    // Double-dabble correction: bump every BCD nibble >= 5 by 3 before the shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Significant digit count: highest nonzero nibble + 1, at least one so zero prints "0".
    always_comb begin
        ndig_c = KW'(1);
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] != 4'd0) begin
                ndig_c = KW'(i + 1);
            end
        end
    end

    // Character at field position k_q: padding, sign, or digit (most significant first).
    always_comb begin
        sign_len  = {{(KW-1){1'b0}}, sgn_q & nz_q};
        field_len = KW'(DIGITS) + {{(KW-1){1'b0}}, sgn_q};
        str_len   = ndig_q + sign_len;
        pad_len   = field_len - str_len;
        if (JUSTIFY != 0) begin
            is_pad = (k_q < pad_len);
            pos    = k_q - pad_len;
        end else begin
            is_pad = (k_q >= str_len);
            pos    = k_q;
        end
        didx   = str_len - KW'(1) - pos;
        digit  = 4'(bcd_q >> {didx, 2'b00});
        char_c = 8'h20;
        if (!is_pad) begin
            if (pos < sign_len) begin
                char_c = neg_q ? 8'h2D : 8'h2B;
            end else begin
                char_c = 8'h30 + {4'h0, digit};
            end
        end
    end

    // Control FSM: latch, take magnitude, convert, size the field, then stream it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            val_q     <= '0;
            mag_q     <= '0;
            sgn_q     <= 1'b0;
            neg_q     <= 1'b0;
            nz_q      <= 1'b0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            ndig_q    <= '0;
            k_q       <= '0;
            out_valid <= 1'b0;
            out_char  <= 8'h00;
            out_last  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        val_q <= value;
                        sgn_q <= signed_mode;
                        state <= S_PREP;
                    end
                end
                S_PREP: begin
                    neg_q <= sgn_q & val_q[WIDTH-1];
                    mag_q <= (sgn_q & val_q[WIDTH-1])
                             ? ((~val_q) + {{(WIDTH-1){1'b0}}, 1'b1})
                             : val_q;
                    nz_q  <= |val_q;
                    bcd_q <= '0;
                    cnt_q <= '0;
                    state <= S_CONV;
                end
                S_CONV: begin
                    bcd_q <= BW'({bcd_adj, mag_q[WIDTH-1]});
                    mag_q <= mag_q << 1;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    ndig_q <= ndig_c;
                    k_q    <= '0;
                    state  <= S_EMIT;
                end
                S_EMIT: begin
                    if (!out_valid || out_ready) begin
                        if (out_valid && out_last) begin
                            out_valid <= 1'b0;
                            out_char  <= 8'h00;
                            out_last  <= 1'b0;
                            state     <= S_IDLE;
                        end else begin
                            out_valid <= 1'b1;
                            out_char  <= char_c;
                            out_last  <= (k_q == field_len - KW'(1));
                            k_q       <= k_q + KW'(1);
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_ascii_dec.sv
// tb/tb_bin_to_ascii_dec.sv - self-checking bench for bin_to_ascii_dec in three configurations
module tb_bin_to_ascii_dec;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  start;
    logic [2:0]  out_ready;
    logic [31:0] value;
    logic        signed_mode;
    logic        busy [3];
    logic        ov   [3];
    logic        ol   [3];
    logic [7:0]  oc   [3];

    int wid [3] = '{8, 8, 16};
    int dig [3] = '{3, 3, 5};
    int jus [3] = '{0, 1, 0};

    int    checks = 0;
    int    errors = 0;
    int    act    = 0;
    string exp_s  = "";
    int    hs     = 0;
    bit    mon_on = 1'b0;
    bit    stall_prev = 1'b0;
    logic [7:0] pc;
    logic       pl;

    always #5 clk = ~clk;

    bin_to_ascii_dec #(.WIDTH(8), .DIGITS(3), .JUSTIFY(0)) u_w8_left (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .value(value[7:0]),
        .signed_mode(signed_mode), .busy(busy[0]), .out_valid(ov[0]),
        .out_ready(out_ready[0]), .out_char(oc[0]), .out_last(ol[0])
    );

    bin_to_ascii_dec #(.WIDTH(8), .DIGITS(3), .JUSTIFY(1)) u_w8_right (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .value(value[7:0]),
        .signed_mode(signed_mode), .busy(busy[1]), .out_valid(ov[1]),
        .out_ready(out_ready[1]), .out_char(oc[1]), .out_last(ol[1])
    );

    bin_to_ascii_dec #(.WIDTH(16), .DIGITS(5), .JUSTIFY(0)) u_w16_left (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .value(value[15:0]),
        .signed_mode(signed_mode), .busy(busy[2]), .out_valid(ov[2]),
        .out_ready(out_ready[2]), .out_char(oc[2]), .out_last(ol[2])
    );

    task automatic chk(input string name, input longint actual, input longint required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, actual, required);
        end
    endtask

    task automatic chk_str(input string name, input string actual, input string required);
        checks++;
        if (actual != required) begin
            errors++;
            $display("FAIL %s actual \"%s\" required \"%s\"", name, actual, required);
        end
    endtask

    // Reference field: decimal text of the interpreted value, sign rule, then pad to DIGITS+signed_mode.
    function automatic string model(input int w, input int d, input int j,
                                    input logic [31:0] v, input bit sm);
        longint x;
        string  s;
        string  pad;
        x = longint'(v) & ((longint'(1) << w) - 1);
        if (sm && x[w-1]) x = x - (longint'(1) << w);
        s = $sformatf("%0d", (x < 0) ? -x : x);
        if (x < 0) s = {"-", s};
        else if (sm && x != 0) s = {"+", s};
        pad = "";
        for (int i = s.len(); i < d + int'(sm); i++) pad = {pad, " "};
        return (j != 0) ? {pad, s} : {s, pad};
    endfunction

    // Every presented character is checked against the model; stalled characters must not move.
    always @(negedge clk) begin
        if (rst_n && mon_on) begin
            if (ov[act]) begin
                if (hs < exp_s.len()) begin
                    chk($sformatf("char%0d", hs), oc[act], exp_s[hs]);
                    chk($sformatf("last%0d", hs), ol[act], (hs == exp_s.len() - 1));
                end else begin
                    chk("extra_char", 1, 0);
                end
                if (stall_prev) begin
                    chk("stall_char", oc[act], pc);
                    chk("stall_last", ol[act], pl);
                end
                stall_prev = !out_ready[act];
                pc = oc[act];
                pl = ol[act];
                if (out_ready[act]) hs++;
            end else begin
                stall_prev = 1'b0;
            end
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic run(input int s, input logic [31:0] v, input bit sm, input string lit,
                       input bit rnd, input bit poke);
        string m;
        int    cyc;
        int    first;
        int    f;
        m = model(wid[s], dig[s], jus[s], v, sm);
        chk_str($sformatf("model_%0d_%0h", s, v), m, lit);
        f = dig[s] + int'(sm);
        act = s;
        exp_s = m;
        hs = 0;
        mon_on = 1'b1;
        value = v;
        signed_mode = sm;
        start[s] = 1'b1;
        out_ready[s] = 1'b1;
        @(posedge clk); #1;
        start[s] = 1'b0;
        value = $urandom;
        signed_mode = ~sm;
        cyc = 0;
        first = -1;
        while (busy[s] && cyc < 500) begin
            if (ov[s] && first < 0) first = cyc;
            start[s] = poke && (first == cyc);
            value = $urandom;
            if (rnd) out_ready[s] = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            cyc++;
        end
        start[s] = 1'b0;
        out_ready[s] = 1'b1;
        chk("done_in_time", (cyc < 500), 1);
        chk("handshakes", hs, f);
        chk("first_valid", first, wid[s] + 3);
        if (!rnd) chk("total_cycles", cyc, wid[s] + 3 + f);
        @(posedge clk); #1;
        chk("idle_busy", busy[s], 0);
        chk("idle_valid", ov[s], 0);
        mon_on = 1'b0;
    endtask

    task automatic check_reset_outputs();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_busy%0d", i), busy[i], 0);
            chk($sformatf("rst_valid%0d", i), ov[i], 0);
            chk($sformatf("rst_char%0d", i), oc[i], 8'h00);
            chk($sformatf("rst_last%0d", i), ol[i], 0);
        end
    endtask

    task automatic reset_mid(input bit in_emit);
        int cyc;
        mon_on = 1'b0;
        value = 32'h80;
        signed_mode = 1'b1;
        start[0] = 1'b1;
        out_ready[0] = in_emit ? 1'b0 : 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        cyc = 0;
        if (in_emit) begin
            while (!ov[0] && cyc < 100) begin
                @(posedge clk); #1;
                cyc++;
            end
            chk("emit_reached", ov[0], 1);
        end else begin
            repeat (4) @(posedge clk);
            #1;
        end
        chk("pre_reset_busy", busy[0], 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_busy", busy[0], 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        start = '0;
        out_ready = '1;
        value = '0;
        signed_mode = 1'b0;
        rst_n = 1'b0;
        #12;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run(0, 32'h80, 1'b1, "-128",   1'b0, 1'b0);
        run(0, 32'h00, 1'b1, "0   ",   1'b0, 1'b0);
        run(0, 32'h05, 1'b1, "+5  ",   1'b0, 1'b0);
        run(0, 32'hFF, 1'b0, "255",    1'b0, 1'b0);
        run(0, 32'h00, 1'b0, "0  ",    1'b0, 1'b0);
        run(1, 32'hF6, 1'b1, " -10",   1'b0, 1'b0);
        run(1, 32'h7F, 1'b1, "+127",   1'b0, 1'b0);
        run(1, 32'h07, 1'b0, "  7",    1'b0, 1'b0);
        run(2, 32'h8000, 1'b1, "-32768", 1'b0, 1'b0);
        run(2, 32'hFFFF, 1'b0, "65535",  1'b0, 1'b0);
        run(2, 32'h0064, 1'b1, "+100  ", 1'b0, 1'b0);
        run(0, 32'h80, 1'b1, "-128",   1'b1, 1'b1);
        run(1, 32'hF6, 1'b1, " -10",   1'b1, 1'b1);

        reset_mid(1'b0);
        reset_mid(1'b1);
        run(0, 32'h2A, 1'b1, "+42 ",   1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
